aes_key_expansion: RTL and testbench

- Generates the AES-128 round keys 1..10 one at a time from a 128-bit cipher key.
- Feeds the Key_in input of the AddRoundKey stage, one round key per handshake, in round order.
- Uses a valid/ready handshake so the round pipeline can stall key delivery.
- Contains an internal combinational S-box (256-entry case function) for SubWord, and an Rcon generator.

---
 rtl/aes_key_expansion_if.sv | 32 +++
 rtl/aes_key_expansion.sv | 150 +++++++++++++++
 tb/tb_aes_key_expansion.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expansion_if.sv
// aes_key_expansion_if
//   Bundles the key-expansion request and round-key delivery signals.
//   master : consumer side (drives start, key_in, key_ready)
//   slave  : key expansion block (drives round_key, round_num, key_valid, busy, done)
//   start      request expansion of key_in (sampled only while idle)
//   key_in     128-bit cipher key, w0 = key_in[127:96]
//   round_key  current round key, same word ordering as key_in
//   round_num  index of the key on round_key
//   key_valid  round_key/round_num valid
//   key_ready  consumer accepts on key_valid && key_ready
//   busy       high from start acceptance until return to idle
//   done       one-cycle pulse after the last round key is accepted
interface aes_key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expansion.sv
// aes_key_expansion
//   AES-128 key schedule: produces round keys one per valid/ready handshake,
//   in round order, ending with a one-cycle done pulse.
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   kx     aes_key_expansion_if.slave (start/key_in in, round keys out)
//   NR     number of expanded round keys; only 10 (AES-128) is legal
// Optional build macro AES_KEXP_ROUND0_EN: when defined, the cipher key itself
//   is emitted first as round 0 (11 handshakes); otherwise rounds 1..NR only.
module aes_key_expansion #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_key_expansion_if.slave   kx
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_expansion: NR must be 10 (AES-128)");
  end

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_OUT} state_e;

  state_e       state_q;
  logic [127:0] cur_key_q;
  logic [3:0]   round_num_q;
  logic [7:0]   rcon_q;
  logic         key_valid_q;
  logic         busy_q;
  logic         done_q;

  logic [127:0] next_key_d;
  logic [7:0]   rcon_d;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = '0;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // One key-schedule step on the registered key; used only in S_EXPAND.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = cur_key_q[127:96];
    w1 = cur_key_q[95:64];
    w2 = cur_key_q[63:32];
    w3 = cur_key_q[31:0];
    // SubWord(RotWord(w3)): rotate bytes left by one, then substitute
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t ^ {rcon_q, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key_d = {n0, n1, n2, n3};
    rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_key_q   <= '0;
      round_num_q <= '0;
      rcon_q      <= 8'h01;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (kx.start) begin
            cur_key_q   <= kx.key_in;
            round_num_q <= '0;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b1;
`ifdef AES_KEXP_ROUND0_EN
            key_valid_q <= 1'b1;
            state_q     <= S_OUT;
`else
            state_q     <= S_EXPAND;
`endif
          end
        end
        S_EXPAND: begin
          cur_key_q   <= next_key_d;
          round_num_q <= round_num_q + 4'd1;
          rcon_q      <= rcon_d;
          key_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (key_valid_q && kx.key_ready) begin
            key_valid_q <= 1'b0;
            if (round_num_q == LastRound) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_EXPAND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign kx.round_key = cur_key_q;
  assign kx.round_num = round_num_q;
  assign kx.key_valid = key_valid_q;
  assign kx.busy      = busy_q;
  assign kx.done      = done_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
module tb_aes_key_expansion;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  aes_key_expansion_if kif ();

  aes_key_expansion #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .kx    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef AES_KEXP_ROUND0_EN
  localparam int FIRST     = 0;
  localparam int FIRST_LAT = 0;
  localparam int DONE_LAT  = 21;
`else
  localparam int FIRST     = 1;
  localparam int FIRST_LAT = 1;
  localparam int DONE_LAT  = 20;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [127:0] RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (kif.key_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    ok = (kif.key_valid === 1'b1);
  endtask

  task automatic start_run(input logic [127:0] k, output int t0);
    kif.key_in = k;
    kif.start  = 1'b1;
    tick();
    kif.start  = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kif.start = 1'b1;
    kif.key_in = FIPS_KEY;
    kif.key_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    kif.start = 1'b0;
    vectors++; if (kif.key_valid !== 1'b0) begin $display("FAIL reset_key_valid got %b want 0", kif.key_valid); miscompares++; end
    vectors++; if (kif.busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", kif.busy); miscompares++; end
    vectors++; if (kif.done !== 1'b0) begin $display("FAIL reset_done got %b want 0", kif.done); miscompares++; end
    vectors++; if (kif.round_num !== 4'd0) begin $display("FAIL reset_round_num got %0d want 0", kif.round_num); miscompares++; end
    vectors++; if (kif.round_key !== 128'h0) begin $display("FAIL reset_round_key got %h want 0", kif.round_key); miscompares++; end
    tick();
    vectors++; if (kif.busy !== 1'b0) begin $display("FAIL reset_idle_busy got %b want 0", kif.busy); miscompares++; end
  endtask

  task automatic test_fips_vector();
    bit ok;
    int t0;
    kif.key_ready = 1'b1;
    start_run(FIPS_KEY, t0);
    vectors++; if (kif.busy !== 1'b1) begin $display("FAIL fips_busy got %b want 1", kif.busy); miscompares++; end
    for (int r = FIRST; r <= 10; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL fips_valid_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      if (r == FIRST) begin
        vectors++; if (cyc - t0 != FIRST_LAT) begin $display("FAIL fips_first_latency got %0d want %0d", cyc - t0, FIRST_LAT); miscompares++; end
      end
      vectors++; if (kif.round_num !== 4'(r)) begin $display("FAIL fips_round_num got %0d want %0d", kif.round_num, r); miscompares++; end
      vectors++; if (kif.round_key !== RK[r]) begin $display("FAIL fips_round_key r%0d got %h want %h", r, kif.round_key, RK[r]); miscompares++; end
      tick();
    end
    vectors++; if (kif.done !== 1'b1) begin $display("FAIL fips_done got %b want 1", kif.done); miscompares++; end
    vectors++; if (cyc - t0 != DONE_LAT) begin $display("FAIL fips_done_latency got %0d want %0d", cyc - t0, DONE_LAT); miscompares++; end
    tick();
    vectors++; if (kif.done !== 1'b0) begin $display("FAIL fips_done_pulse got %b want 0", kif.done); miscompares++; end
    vectors++; if (kif.busy !== 1'b0) begin $display("FAIL fips_busy_end got %b want 0", kif.busy); miscompares++; end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t0;
    kif.key_ready = 1'b0;
    start_run(FIPS_KEY, t0);
    for (int r = FIRST; r <= 10; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL bp_valid_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      if (r == 3 || r == 10) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          vectors++; if (kif.key_valid !== 1'b1) begin $display("FAIL bp_stall_valid got %b want 1", kif.key_valid); miscompares++; end
          vectors++; if (kif.round_num !== 4'(r)) begin $display("FAIL bp_stall_round_num got %0d want %0d", kif.round_num, r); miscompares++; end
          vectors++; if (kif.round_key !== RK[r]) begin $display("FAIL bp_stall_key got %h want %h", kif.round_key, RK[r]); miscompares++; end
          vectors++; if (kif.done !== 1'b0) begin $display("FAIL bp_stall_done got %b want 0", kif.done); miscompares++; end
        end
      end
      vectors++; if (kif.round_num !== 4'(r)) begin $display("FAIL bp_round_num got %0d want %0d", kif.round_num, r); miscompares++; end
      vectors++; if (kif.round_key !== RK[r]) begin $display("FAIL bp_round_key r%0d got %h want %h", r, kif.round_key, RK[r]); miscompares++; end
      kif.key_ready = 1'b1;
      tick();
      kif.key_ready = 1'b0;
    end
    vectors++; if (kif.done !== 1'b1) begin $display("FAIL bp_done got %b want 1", kif.done); miscompares++; end
    tick();
    vectors++; if (kif.done !== 1'b0) begin $display("FAIL bp_done_pulse got %b want 0", kif.done); miscompares++; end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int t0;
    kif.key_ready = 1'b1;
    start_run(FIPS_KEY, t0);
    for (int r = FIRST; r <= 10; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL swb_valid_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      vectors++; if (kif.round_num !== 4'(r)) begin $display("FAIL swb_round_num got %0d want %0d", kif.round_num, r); miscompares++; end
      vectors++; if (kif.round_key !== RK[r]) begin $display("FAIL swb_round_key r%0d got %h want %h", r, kif.round_key, RK[r]); miscompares++; end
      if (r == 4) begin
        kif.start  = 1'b1;
        kif.key_in = KEY2;
      end
      tick();
      kif.start = 1'b0;
    end
    vectors++; if (kif.done !== 1'b1) begin $display("FAIL swb_done got %b want 1", kif.done); miscompares++; end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int t0;
    kif.key_ready = 1'b0;
    start_run(FIPS_KEY, t0);
    for (int r = FIRST; r <= 6; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL rst_valid_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      if (r < 6) begin
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
      end
    end
    vectors++; if (kif.round_num !== 4'd6) begin $display("FAIL rst_pre_round_num got %0d want 6", kif.round_num); miscompares++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (kif.key_valid !== 1'b0) begin $display("FAIL rst_mid_valid got %b want 0", kif.key_valid); miscompares++; end
    vectors++; if (kif.busy !== 1'b0) begin $display("FAIL rst_mid_busy got %b want 0", kif.busy); miscompares++; end
    vectors++; if (kif.done !== 1'b0) begin $display("FAIL rst_mid_done got %b want 0", kif.done); miscompares++; end
    vectors++; if (kif.round_num !== 4'd0) begin $display("FAIL rst_mid_round_num got %0d want 0", kif.round_num); miscompares++; end
    kif.key_ready = 1'b1;
    tick();
    vectors++; if (kif.done !== 1'b0 || kif.key_valid !== 1'b0) begin $display("FAIL rst_after_idle got done=%b valid=%b want 0 0", kif.done, kif.key_valid); miscompares++; end
    start_run(KEY2, t0);
    for (int r = FIRST; r <= 10; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL rst_new_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      vectors++; if (kif.round_num !== 4'(r)) begin $display("FAIL rst_new_round_num got %0d want %0d", kif.round_num, r); miscompares++; end
      if (r == 0) begin
        vectors++; if (kif.round_key !== KEY2) begin $display("FAIL rst_new_r0 got %h want %h", kif.round_key, KEY2); miscompares++; end
      end
      if (r == 1) begin
        vectors++; if (kif.round_key !== K2_R1) begin $display("FAIL rst_new_r1 got %h want %h", kif.round_key, K2_R1); miscompares++; end
      end
      if (r == 10) begin
        vectors++; if (kif.round_key !== K2_R10) begin $display("FAIL rst_new_r10 got %h want %h", kif.round_key, K2_R10); miscompares++; end
      end
      tick();
    end
    vectors++; if (kif.done !== 1'b1) begin $display("FAIL rst_new_done got %b want 1", kif.done); miscompares++; end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t0;
    kif.key_ready = 1'b1;
    start_run(FIPS_KEY, t0);
    for (int r = FIRST; r <= 10; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL b2b_first_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      vectors++; if (kif.round_key !== RK[r]) begin $display("FAIL b2b_first_key r%0d got %h want %h", r, kif.round_key, RK[r]); miscompares++; end
      tick();
    end
    vectors++; if (kif.done !== 1'b1) begin $display("FAIL b2b_done1 got %b want 1", kif.done); miscompares++; end
    start_run(KEY2, t0);
    vectors++; if (kif.busy !== 1'b1) begin $display("FAIL b2b_accept_busy got %b want 1", kif.busy); miscompares++; end
    vectors++; if (kif.done !== 1'b0) begin $display("FAIL b2b_done_clear got %b want 0", kif.done); miscompares++; end
    for (int r = FIRST; r <= 10; r++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL b2b_second_timeout round %0d got key_valid=%b want 1", r, kif.key_valid); miscompares++; return; end
      vectors++; if (kif.round_num !== 4'(r)) begin $display("FAIL b2b_round_num got %0d want %0d", kif.round_num, r); miscompares++; end
      if (r == 0) begin
        vectors++; if (kif.round_key !== KEY2) begin $display("FAIL b2b_r0 got %h want %h", kif.round_key, KEY2); miscompares++; end
      end
      if (r == 1) begin
        vectors++; if (kif.round_key !== K2_R1) begin $display("FAIL b2b_r1 got %h want %h", kif.round_key, K2_R1); miscompares++; end
      end
      if (r == 10) begin
        vectors++; if (kif.round_key !== K2_R10) begin $display("FAIL b2b_r10 got %h want %h", kif.round_key, K2_R10); miscompares++; end
      end
      tick();
    end
    vectors++; if (kif.done !== 1'b1) begin $display("FAIL b2b_done2 got %b want 1", kif.done); miscompares++; end
    vectors++; if (cyc - t0 != DONE_LAT) begin $display("FAIL b2b_done2_latency got %0d want %0d", cyc - t0, DONE_LAT); miscompares++; end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    kif.start = 1'b0;
    kif.key_in = '0;
    kif.key_ready = 1'b0;
    test_reset();
    test_fips_vector();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
